// File: rtl/ysyx_24110015_axi_xbar_if.sv
// Single-beat AXI bus without ID or burst fields: 32-bit address/data,
// 4-bit write strobe, 2-bit response.
interface axi_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_24110015_axi_xbar.sv
// 1-to-2 AXI crossbar: reads are routed to the CLINT or to the memory fabric by
// address; writes go to memory only, writes into the CLINT window get DECERR.
// Read and write paths are independent, each with one outstanding transaction.
module ysyx_24110015_axi_xbar #(
    parameter logic [31:0] CLINT_LO = 32'h0200_0000,
    parameter logic [31:0] CLINT_HI = 32'h0200_FFFF
) (
    input logic   clk,
    input logic   rst,
    axi_if.slave  up,
    axi_if.master clint,
    axi_if.master mem
);

    typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;
    typedef enum logic [1:0] {WIdle, WAw, WB, WErr} wr_state_e;

    function automatic logic in_clint(input logic [31:0] addr);
        return (addr >= CLINT_LO) && (addr <= CLINT_HI);
    endfunction

    // ---------------- read path ----------------
    rd_state_e   rd_state;
    logic        rsel;            // 1: CLINT, 0: memory
    logic [31:0] araddr_q;
    logic        arready_q;
    logic        clint_arvalid_q;
    logic        mem_arvalid_q;
    logic        sel_arready;
    logic        sel_rvalid;

    assign sel_arready = rsel ? clint.arready : mem.arready;
    assign sel_rvalid  = rsel ? clint.rvalid  : mem.rvalid;

    // Read FSM: accept AR, issue it to the decoded slave, then pass R through.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state        <= RIdle;
            rsel            <= 1'b0;
            araddr_q        <= 32'h0;
            arready_q       <= 1'b1;
            clint_arvalid_q <= 1'b0;
            mem_arvalid_q   <= 1'b0;
        end else begin
            unique case (rd_state)
                RIdle: begin
                    if (up.arvalid) begin
                        araddr_q        <= up.araddr;
                        rsel            <= in_clint(up.araddr);
                        arready_q       <= 1'b0;
                        clint_arvalid_q <= in_clint(up.araddr);
                        mem_arvalid_q   <= !in_clint(up.araddr);
                        rd_state        <= RAddr;
                    end
                end
                RAddr: begin
                    if (sel_arready) begin
                        clint_arvalid_q <= 1'b0;
                        mem_arvalid_q   <= 1'b0;
                        rd_state        <= RData;
                    end
                end
                RData: begin
                    if (sel_rvalid && up.rready) begin
                        arready_q <= 1'b1;
                        rd_state  <= RIdle;
                    end
                end
                default: rd_state <= RIdle;
            endcase
        end
    end

    // Read outputs: AR side from registers, R side routed only while in RData.
    always_comb begin
        up.arready    = arready_q;
        clint.arvalid = clint_arvalid_q;
        clint.araddr  = araddr_q;
        mem.arvalid   = mem_arvalid_q;
        mem.araddr    = araddr_q;
        up.rvalid     = 1'b0;
        up.rdata      = 32'h0;
        up.rresp      = 2'b00;
        clint.rready  = 1'b0;
        mem.rready    = 1'b0;
        if (rd_state == RData) begin
            up.rvalid    = sel_rvalid;
            up.rdata     = rsel ? clint.rdata : mem.rdata;
            up.rresp     = rsel ? clint.rresp : mem.rresp;
            clint.rready = rsel & up.rready;
            mem.rready   = !rsel & up.rready;
        end
    end

    // ---------------- write path ----------------
    wr_state_e   wr_state;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awready_q;       // low in WIdle means AW already latched
    logic        wready_q;        // low in WIdle means W already latched
    logic        mem_awvalid_q;
    logic        mem_wvalid_q;
    logic        berr_q;
    logic        aw_take;
    logic        w_take;
    logic        aw_have;
    logic        w_have;
    logic [31:0] awaddr_next;
    logic        aw_ok;
    logic        w_ok;

    // Handshake bookkeeping: the decision to leave WIdle uses this cycle's AW/W too.
    always_comb begin
        aw_take     = (wr_state == WIdle) && awready_q && up.awvalid;
        w_take      = (wr_state == WIdle) && wready_q && up.wvalid;
        aw_have     = aw_take || !awready_q;
        w_have      = w_take || !wready_q;
        awaddr_next = aw_take ? up.awaddr : awaddr_q;
        aw_ok       = !mem_awvalid_q || mem.awready;
        w_ok        = !mem_wvalid_q || mem.wready;
    end

    // Write FSM: collect AW and W, then forward to memory or answer DECERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state      <= WIdle;
            awaddr_q      <= 32'h0;
            wdata_q       <= 32'h0;
            wstrb_q       <= 4'h0;
            awready_q     <= 1'b1;
            wready_q      <= 1'b1;
            mem_awvalid_q <= 1'b0;
            mem_wvalid_q  <= 1'b0;
            berr_q        <= 1'b0;
        end else begin
            unique case (wr_state)
                WIdle: begin
                    if (aw_take) begin
                        awaddr_q  <= up.awaddr;
                        awready_q <= 1'b0;
                    end
                    if (w_take) begin
                        wdata_q  <= up.wdata;
                        wstrb_q  <= up.wstrb;
                        wready_q <= 1'b0;
                    end
                    if (aw_have && w_have) begin
                        if (in_clint(awaddr_next)) begin
                            berr_q   <= 1'b1;
                            wr_state <= WErr;
                        end else begin
                            mem_awvalid_q <= 1'b1;
                            mem_wvalid_q  <= 1'b1;
                            wr_state      <= WAw;
                        end
                    end
                end
                WAw: begin
                    if (mem.awready) mem_awvalid_q <= 1'b0;
                    if (mem.wready)  mem_wvalid_q  <= 1'b0;
                    if (aw_ok && w_ok) wr_state <= WB;
                end
                WB: begin
                    if (mem.bvalid && up.bready) begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_state  <= WIdle;
                    end
                end
                WErr: begin
                    if (up.bready) begin
                        berr_q    <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_state  <= WIdle;
                    end
                end
                default: wr_state <= WIdle;
            endcase
        end
    end

    // Write outputs; the CLINT write channels are never used.
    always_comb begin
        up.awready    = awready_q;
        up.wready     = wready_q;
        mem.awvalid   = mem_awvalid_q;
        mem.awaddr    = awaddr_q;
        mem.wvalid    = mem_wvalid_q;
        mem.wdata     = wdata_q;
        mem.wstrb     = wstrb_q;
        mem.bready    = (wr_state == WB) & up.bready;
        up.bvalid     = berr_q | ((wr_state == WB) & mem.bvalid);
        up.bresp      = berr_q ? 2'b11 : ((wr_state == WB) ? mem.bresp : 2'b00);
        clint.awvalid = 1'b0;
        clint.awaddr  = 32'h0;
        clint.wvalid  = 1'b0;
        clint.wdata   = 32'h0;
        clint.wstrb   = 4'h0;
        clint.bready  = 1'b0;
    end

endmodule
